// File: rtl/rtc_pkg.sv
// Shared RTC definitions: ID register address map, PrimeCell ID bytes and the
// APB phase-tracker state encoding.
package rtc_pkg;

    localparam logic [11:0] IdBaseAddr = 12'hFE0;

    localparam logic [2:0] IdxPeriph0 = 3'd0;
    localparam logic [2:0] IdxPeriph1 = 3'd1;
    localparam logic [2:0] IdxPeriph2 = 3'd2;
    localparam logic [2:0] IdxPeriph3 = 3'd3;
    localparam logic [2:0] IdxCell0   = 3'd4;
    localparam logic [2:0] IdxCell1   = 3'd5;
    localparam logic [2:0] IdxCell2   = 3'd6;
    localparam logic [2:0] IdxCell3   = 3'd7;

    localparam logic [7:0] PCellId0 = 8'h0D;
    localparam logic [7:0] PCellId1 = 8'hF0;
    localparam logic [7:0] PCellId2 = 8'h05;
    localparam logic [7:0] PCellId3 = 8'hB1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

    // PADDR is a word address, so the 0xFE0-0xFFC block is word bits [9:3] == 7'h7F.
    function automatic logic id_addr_hit(logic [9:0] paddr);
        return paddr[9:3] == IdBaseAddr[11:5];
    endfunction

endpackage

// File: rtl/rtc_id_regs_if.sv
// APB slave-side bundle for the RTC ID register bank; signal names follow the
// RTC top-level read-data mux.
interface rtc_id_regs_if;

    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [9:0] PADDR;
    logic [7:0] PRDATA_ID;
    logic       ID_HIT;
    logic       PREADY_ID;
    logic       PSLVERR_ID;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR,
        input  PRDATA_ID, ID_HIT, PREADY_ID, PSLVERR_ID
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR,
        output PRDATA_ID, ID_HIT, PREADY_ID, PSLVERR_ID
    );

endinterface

// File: rtl/rtc_apb_fsm.sv
// Reusable APB phase tracker: flags the setup-phase and access-phase edges and
// an access phase seen without a preceding setup.
module rtc_apb_fsm
    import rtc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psel_i,
    input  logic       penable_i,
    output logic       setup_pulse_o,
    output logic       access_pulse_o,
    output logic       violation_o,
    output apb_state_e state_o
);

    apb_state_e state_q, state_d;

    always_comb begin
        state_d        = state_q;
        setup_pulse_o  = 1'b0;
        access_pulse_o = 1'b0;
        violation_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    state_d       = StSetup;
                    setup_pulse_o = 1'b1;
                end else if (psel_i && penable_i) begin
                    violation_o = 1'b1;
                end
            end
            StSetup: begin
                if (psel_i && penable_i) begin
                    state_d        = StAccess;
                    access_pulse_o = 1'b1;
                end else if (!psel_i) begin
                    state_d = StIdle;
                end else begin
                    // Setup held another cycle: re-sample the (possibly new) address.
                    setup_pulse_o = 1'b1;
                end
            end
            StAccess: begin
                if (psel_i && !penable_i) begin
                    state_d       = StSetup;
                    setup_pulse_o = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rtc_id_regs.sv
// RTC read-only PeriphID/PCellID bank at 0xFE0-0xFFC with one-shot capture of
// the revision tie-off into PeriphID2[4].
module rtc_id_regs
    import rtc_pkg::*;
#(
    parameter logic [11:0] PART_NUM  = 12'h031,
    parameter logic [7:0]  DESIGNER  = 8'h41,
    parameter logic [2:0]  REV_UPPER = 3'b000,
    parameter logic [7:0]  CONFIG    = 8'h00,
    parameter bit          ERR_EN    = 1'b1
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          Revision,
    rtc_id_regs_if.slave  apb,
    output logic          RevisionQ
);

    logic       setup_pulse, access_pulse, violation;
    apb_state_e fsm_state;

    rtc_apb_fsm u_apb_fsm (
        .clk_i          (PCLK),
        .rst_i          (PRESET),
        .psel_i         (apb.PSEL),
        .penable_i      (apb.PENABLE),
        .setup_pulse_o  (setup_pulse),
        .access_pulse_o (access_pulse),
        .violation_o    (violation),
        .state_o        (fsm_state)
    );

    // Outputs clear on every non-setup edge, so the access pulse and state are not needed here.
    logic unused_fsm;
    assign unused_fsm = access_pulse ^ (^fsm_state);

    logic       capture_done_q, revision_q, revision_d;
    logic [7:0] prdata_q, prdata_d;
    logic       hit_q, hit_d, pready_q, pready_d, pslverr_q, pslverr_d;
    logic [7:0] id_byte;
    logic       addr_hit;

    // Decode sees the next-state revision so a read on the capture edge gets the new bit.
    assign revision_d = capture_done_q ? revision_q : Revision;
    assign addr_hit   = id_addr_hit(apb.PADDR);

    always_comb begin
        id_byte = '0;
        unique case (apb.PADDR[2:0])
            IdxPeriph0: id_byte = PART_NUM[7:0];
            IdxPeriph1: id_byte = {DESIGNER[3:0], PART_NUM[11:8]};
            IdxPeriph2: id_byte = {REV_UPPER, revision_d, DESIGNER[7:4]};
            IdxPeriph3: id_byte = CONFIG;
            IdxCell0:   id_byte = PCellId0;
            IdxCell1:   id_byte = PCellId1;
            IdxCell2:   id_byte = PCellId2;
            IdxCell3:   id_byte = PCellId3;
            default:    id_byte = '0;
        endcase
    end

    always_comb begin
        prdata_d  = '0;
        hit_d     = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (violation) begin
            pready_d = 1'b1;
        end else if (setup_pulse && addr_hit) begin
            hit_d    = 1'b1;
            pready_d = 1'b1;
            if (apb.PWRITE) begin
                pslverr_d = ERR_EN;
            end else begin
                prdata_d = id_byte;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            capture_done_q <= 1'b0;
            revision_q     <= 1'b0;
            prdata_q       <= '0;
            hit_q          <= 1'b0;
            pready_q       <= 1'b0;
            pslverr_q      <= 1'b0;
        end else begin
            capture_done_q <= 1'b1;
            revision_q     <= revision_d;
            prdata_q       <= prdata_d;
            hit_q          <= hit_d;
            pready_q       <= pready_d;
            pslverr_q      <= pslverr_d;
        end
    end

    assign apb.PRDATA_ID  = prdata_q;
    assign apb.ID_HIT     = hit_q;
    assign apb.PREADY_ID  = pready_q;
    assign apb.PSLVERR_ID = pslverr_q;
    assign RevisionQ      = revision_q;

endmodule
